// File: rtl/jpeg_fifo_arbiter.sv
// jpeg_fifo_arbiter
// Round-robin, burst-locking write arbiter for a shared 16x32 sync FIFO (no full
// flag, 1-cycle registered read), plus a read side that keeps the FIFO draining
// at one word per cycle through a 2-entry skid buffer.
// Optional feature: define JPEG_ARB_STATS_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
module jpeg_fifo_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           fifo_write_data,
  output logic                        fifo_write_en,
  output logic                        fifo_read_req,
  input  logic [DATA_W-1:0]           fifo_read_data,
  input  logic                        fifo_rdata_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CW-1:0]               fifo_count,
  output logic [15:0]                 stall_cycles
);

  typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_gnt_idx;
  logic [CW-1:0]       r_count;
  logic                r_inflight;
  logic [1:0]          r_skid_cnt;
  logic [DATA_W-1:0]   r_skid [2];

  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_found;
  logic [IW-1:0]       w_scan;
  logic [IW-1:0]       w_gnt_idx;
  logic                w_gnt_vld;
  logic                w_space;
  logic                w_we;
  logic                w_last;
  logic                w_rd;
  logic                w_pop;

  // Cyclic successor of a requester index.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p);
    return (p == IW'(NUM_REQ - 1)) ? '0 : p + IW'(1);
  endfunction

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_arb_idx   = r_rr_ptr;
    w_arb_found = 1'b0;
    w_scan      = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_arb_found && req_valid[w_scan]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_scan;
      end
      w_scan = next_idx(w_scan);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ARB;
    else     r_state <= w_state_next;
  end

  // FSM next state: a non-last accepted word locks the grant until its last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARB:   if (w_we && !w_last) w_state_next = ST_BURST;
      ST_BURST: if (w_we && w_last)  w_state_next = ST_ARB;
      default:  w_state_next = ST_ARB;
    endcase
  end

  // FSM outputs: one-hot ready to the granted producer while the FIFO has room.
  always_comb begin
    w_gnt_idx = (r_state == ST_BURST) ? r_gnt_idx : w_arb_idx;
    w_gnt_vld = (r_state == ST_BURST) || w_arb_found;
    w_space   = (r_count < CW'(DEPTH));
    req_ready = '0;
    if (!rst && w_gnt_vld && w_space) req_ready[w_gnt_idx] = 1'b1;
    w_we            = |(req_valid & req_ready);
    w_last          = req_last[w_gnt_idx];
    fifo_write_data = req_data[w_gnt_idx*DATA_W +: DATA_W];
  end

  assign fifo_write_en = w_we;

  // Grant lock and round-robin pointer: the pointer moves past a requester only
  // once its burst has finished, so bursts are never interleaved.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
    end else if (w_we) begin
      if (r_state == ST_ARB) r_gnt_idx <= w_arb_idx;
      if (w_last)            r_rr_ptr  <= next_idx(w_gnt_idx);
    end
  end

  // Read request: keep at most two words between the FIFO output and the
  // consumer (one in flight, skid contents), counting this cycle's pop as freed.
  always_comb begin
    w_pop = out_valid && out_ready;
    w_rd  = !rst && (r_count != '0) &&
            ((3'(r_inflight) + 3'(r_skid_cnt)) < (3'd2 + 3'(w_pop)));
  end

  assign fifo_read_req = w_rd;

  // Occupancy: reads are subtracted when issued, so count==0 means empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      case ({w_we, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Skid occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_cnt <= '0;
    end else begin
      case ({fifo_rdata_valid, w_pop})
        2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  // Skid data: entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk) begin
    case ({fifo_rdata_valid, w_pop})
      2'b10: r_skid[r_skid_cnt[0]] <= fifo_read_data;
      2'b01: r_skid[0] <= r_skid[1];
      2'b11: begin
        if (r_skid_cnt == 2'd1) begin
          r_skid[0] <= fifo_read_data;
        end else begin
          r_skid[0] <= r_skid[1];
          r_skid[1] <= fifo_read_data;
        end
      end
      default: ;
    endcase
  end

  assign out_valid  = (r_skid_cnt != 2'd0);
  assign out_data   = r_skid[0];
  assign fifo_count = r_count;

`ifdef JPEG_ARB_STATS_EN
  logic [15:0] r_stall;

  // Count cycles where some producer waits and nothing is written; saturating.
  always_ff @(posedge clk) begin
    if (rst)                                          r_stall <= '0;
    else if ((|req_valid) && !w_we && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_jpeg_fifo_arbiter.sv
// tb_jpeg_fifo_arbiter
// Randomized bench: producers issue bursts, the consumer throttles, and a
// behavioural FIFO answers read requests. A reference model (grant rules,
// word counts, ordered scoreboard) predicts every DUT output each cycle.
module tb_jpeg_fifo_arbiter;

  localparam int NR    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last  = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     fifo_write_data;
  logic              fifo_write_en;
  logic              fifo_read_req;
  logic [DW-1:0]     fifo_read_data = '0;
  logic              fifo_rdata_valid = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       stall_cycles;

  jpeg_fifo_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_write_data(fifo_write_data), .fifo_write_en(fifo_write_en),
    .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
    .fifo_rdata_valid(fifo_rdata_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit           m_locked;
  int           m_owner, m_ptr;
  int           m_cnt;      // words written minus reads requested
  int           m_infl;     // words requested last cycle, arriving next
  int           m_skid;     // words waiting at the consumer side
  int           m_stall;
  logic [DW-1:0] exp_q[$];  // every accepted, not yet consumed word in order

  // Behavioural FIFO
  logic [DW-1:0] fq[$];

  // Producer state
  int p_seq  [NR];
  int p_left [NR];

  int mode;       // 0 random, 1 only producer 0 + consumer stalled, 2 only producer 0 streaming
  int max_cnt;

  function automatic logic [DW-1:0] mk_word(input int i, input int s);
    return {4'(i), 28'(s)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_cnt = 0; m_infl = 0; m_skid = 0; m_stall = 0;
    exp_q.delete();
  endtask

  task automatic drive_producers(input int acc_idx);
    for (int i = 0; i < NR; i++) begin
      if (i == acc_idx) begin
        p_seq[i]++;
        p_left[i]--;
        req_valid[i] = 1'b0;
      end
      if (rst) req_valid[i] = 1'b0;
      if (!rst && !req_valid[i] && (mode == 0 || i == 0) && $urandom_range(0, 3) != 0) begin
        if (p_left[i] <= 0) p_left[i] = $urandom_range(1, 4);
        req_valid[i] = 1'b1;
      end
      req_last[i] = (p_left[i] == 1);
      req_data[i*DW +: DW] = mk_word(i, p_seq[i]);
    end
    case (mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 4) != 0);
    endcase
    if (rst) out_ready = 1'b0;
  endtask

  // One clock: predict and compare at the falling edge, commit, then drive.
  task automatic step();
    int g, idx, acc;
    bit gv, pop, exp_we, exp_rd, act_we, act_rd;
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] act_wd;
    @(negedge clk);
    gv = 0; g = 0;
    if (m_locked) begin
      gv = 1; g = m_owner;
    end else begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!gv && req_valid[idx]) begin gv = 1; g = idx; end
      end
    end
    exp_ready = '0;
    if (!rst && gv && m_cnt < DEPTH) exp_ready[g] = 1'b1;
    exp_we = gv && exp_ready[g] && req_valid[g];
    pop    = (m_skid > 0) && out_ready;
    exp_rd = !rst && (m_cnt > 0) && (m_infl + m_skid - int'(pop) < 2);

    check_val("req_ready", 64'(req_ready), 64'(exp_ready));
    check_val("write_en", 64'(fifo_write_en), 64'(exp_we));
    if (exp_we) check_val("write_data", 64'(fifo_write_data), 64'(mk_word(g, p_seq[g])));
    check_val("fifo_count", 64'(fifo_count), 64'(m_cnt));
    check_val("read_req", 64'(fifo_read_req), 64'(exp_rd));
    check_val("out_valid", 64'(out_valid), 64'(m_skid > 0));
    if (m_skid > 0 && exp_q.size() > 0) check_val("out_data", 64'(out_data), 64'(exp_q[0]));
`ifdef JPEG_ARB_STATS_EN
    check_val("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`else
    check_val("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);

    if (pop && exp_q.size() > 0) begin
      $display("t=%0t consume %08h (fifo_count=%0d)", $time, exp_q[0], m_cnt);
      void'(exp_q.pop_front());
    end

    acc = -1;
    act_we = fifo_write_en; act_rd = fifo_read_req; act_wd = fifo_write_data;
    if (rst) begin
      model_reset();
    end else begin
      if ((|req_valid) && !exp_we && m_stall < 65535) m_stall++;
      m_skid = m_skid + m_infl - int'(pop);
      m_infl = int'(exp_rd);
      m_cnt  = m_cnt + int'(exp_we) - int'(exp_rd);
      if (exp_we) begin
        acc = g;
        exp_q.push_back(mk_word(g, p_seq[g]));
        if (req_last[g]) begin
          m_locked = 0; m_ptr = (g + 1) % NR;
        end else begin
          m_locked = 1; m_owner = g;
        end
      end
    end

    @(posedge clk);
    #1;
    if (rst) begin
      fq.delete();
      fifo_rdata_valid = 1'b0;
    end else begin
      fifo_rdata_valid = 1'b0;
      if (act_rd) begin
        check_val("fifo_nonempty_on_read", 64'(fq.size() > 0), 64'd1);
        if (fq.size() > 0) fifo_read_data = fq.pop_front();
        fifo_rdata_valid = 1'b1;
      end
      if (act_we) begin
        check_val("fifo_room_on_write", 64'(fq.size() < DEPTH), 64'd1);
        fq.push_back(act_wd);
      end
    end
    drive_producers(acc);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NR; i++) begin p_seq[i] = 0; p_left[i] = 0; end
    model_reset();
    max_cnt = 0;
    mode = 2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_producers(-1);
    step();                 // reset cycle itself: outputs must be quiet
    rst = 1'b0;
    drive_producers(-1);

    mode = 2; repeat (40) step();
    mode = 0; repeat (400) step();

    mode = 1; max_cnt = 0; repeat (60) step();
    check_val("count_reaches_depth", 64'(max_cnt), 64'(DEPTH));
    mode = 2; repeat (40) step();

    // Fill partially, then reset in the middle of traffic.
    mode = 1; guard = 0;
    while (m_cnt < 7 && guard < 100) begin step(); guard++; end
    check_val("reached_count_7", 64'(m_cnt >= 7), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_producers(-1);
    mode = 0; repeat (300) step();
    mode = 2; repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
